// File: rtl/battle_pkg.sv
// Shared codes for the battle flow controller.
// Holds the keyboard, page and action-cursor encodings, plus the attack
// damage curve applied to the ATTACK marker position.
package battle_pkg;

  typedef enum logic [3:0] {
    K_IDLE  = 4'd0,
    K_UP    = 4'd1,
    K_LEFT  = 4'd2,
    K_DOWN  = 4'd3,
    K_RIGHT = 4'd4,
    K_ENTER = 4'd5
  } key_e;

  typedef enum logic [3:0] {
    PG_NULL     = 4'd0,
    PG_MENU     = 4'd1,
    PG_START    = 4'd8,
    PG_DODGE    = 4'd9,
    PG_ATTACK   = 4'd10,
    PG_ACTION   = 4'd11,
    PG_GAMEOVER = 4'd12,
    PG_WIN      = 4'd13
  } page_e;

  typedef enum logic [1:0] {
    ACT_FIGHT = 2'd0,
    ACT_ACT   = 2'd1,
    ACT_ITEM  = 2'd2,
    ACT_MERCY = 2'd3
  } act_e;

  // Damage peaks at marker 8 and falls off linearly on both sides.
  function automatic logic [3:0] atk_power(input logic [3:0] m);
    logic [3:0] d;
    d = (m >= 4'd8) ? (m - 4'd8) : (4'd8 - m);
    return 4'd8 - d;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Keyboard edge detector.
// Registers the raw key code (codes 6..15 fold to IDLE) and emits a one-cycle
// event when a non-IDLE code differs from the previously sampled one, so a
// held key yields exactly one event.
// Ports: clk, reset (async, active high), i_keyboard raw code,
//        o_kev one-cycle event, o_key code that caused the event.
module key_edge
  import battle_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] i_keyboard,
  output logic       o_kev,
  output logic [3:0] o_key
);

  logic [3:0] w_norm;
  logic [3:0] r_prev;

  assign w_norm = (i_keyboard > K_ENTER) ? K_IDLE : i_keyboard;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev <= K_IDLE;
      o_kev  <= 1'b0;
      o_key  <= K_IDLE;
    end else begin
      r_prev <= w_norm;
      o_kev  <= (w_norm != K_IDLE) && (w_norm != r_prev);
      o_key  <= w_norm;
    end
  end

endmodule

// File: rtl/battle_sequencer.sv
// Top-level game-flow controller: MENU -> START -> ACTION -> ATTACK/DODGE.
// Ports: clk, reset (async, active high), tick frame strobe, keyboard code,
//        isDeath / monster_dead level flags from the HP logic;
//        state {page,substage}, player_instruction + is_move (DODGE only),
//        attack_fire pulse with attack_power, action_sel cursor at ENTER.
module battle_sequencer
  import battle_pkg::*;
#(
  parameter int START_TICKS = 60,
  parameter int ATTACK_STEP = 4,
  parameter int DODGE_TICKS = 300,
  parameter int CNT_W       = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [3:0] keyboard,
  input  logic       isDeath,
  input  logic       monster_dead,
  output logic [7:0] state,
  output logic [3:0] player_instruction,
  output logic       is_move,
  output logic       attack_fire,
  output logic [3:0] attack_power,
  output logic [1:0] action_sel
);

  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TICKS - 1);
  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(ATTACK_STEP - 1);
  localparam logic [CNT_W-1:0] DODGE_LAST = CNT_W'(DODGE_TICKS - 1);

  page_e            r_page, w_page_n;
  logic [3:0]       r_sub, w_sub_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic             w_fire_n;
  logic [3:0]       w_power_n, w_pi_n;
  logic [1:0]       w_sel_n;
  logic             w_kev, w_enter, w_battle;
  logic [3:0]       w_key;

  key_edge u_key (
    .clk       (clk),
    .reset     (reset),
    .i_keyboard(keyboard),
    .o_kev     (w_kev),
    .o_key     (w_key)
  );

  assign w_enter  = w_kev && (w_key == K_ENTER);
  assign w_battle = (r_page == PG_START) || (r_page == PG_DODGE) ||
                    (r_page == PG_ATTACK) || (r_page == PG_ACTION);
  assign state    = {r_page, r_sub};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_page             <= PG_NULL;
      r_sub              <= 4'd0;
      r_cnt              <= '0;
      attack_fire        <= 1'b0;
      attack_power       <= 4'd0;
      action_sel         <= 2'd0;
      player_instruction <= K_IDLE;
      is_move            <= 1'b0;
    end else begin
      r_page             <= w_page_n;
      r_sub              <= w_sub_n;
      r_cnt              <= w_cnt_n;
      attack_fire        <= w_fire_n;
      attack_power       <= w_power_n;
      action_sel         <= w_sel_n;
      player_instruction <= w_pi_n;
      is_move            <= (w_page_n == PG_DODGE);
    end
  end

  always_comb begin
    w_page_n  = r_page;
    w_sub_n   = r_sub;
    w_cnt_n   = r_cnt;
    w_fire_n  = 1'b0;
    w_power_n = attack_power;
    w_sel_n   = action_sel;

    // HP flags outrank every timer/key transition, including a due attack.
    if (w_battle && isDeath) begin
      w_page_n = PG_GAMEOVER;
      w_sub_n  = 4'd0;
      w_cnt_n  = '0;
    end else if (w_battle && monster_dead) begin
      w_page_n = PG_WIN;
      w_sub_n  = 4'd0;
      w_cnt_n  = '0;
    end else begin
      case (r_page)
        PG_NULL: begin
          w_page_n = PG_MENU;
          w_sub_n  = 4'd0;
        end
        PG_MENU: begin
          if (w_kev && (w_key == K_UP || w_key == K_DOWN))
            w_sub_n = {3'd0, ~r_sub[0]};
          else if (w_enter && r_sub[0] == 1'b0) begin
            w_page_n = PG_START;
            w_sub_n  = 4'd0;
            w_cnt_n  = '0;
          end
        end
        PG_START: begin
          if (tick) begin
            if (r_cnt == START_LAST) begin
              w_page_n = PG_ACTION;
              w_sub_n  = 4'd0;
              w_cnt_n  = '0;
            end else
              w_cnt_n = r_cnt + 1'b1;
          end
        end
        PG_ACTION: begin
          // Cursor lives in substage[1:0]; 2-bit arithmetic gives the wrap.
          if (w_kev && w_key == K_RIGHT)
            w_sub_n = {2'd0, r_sub[1:0] + 2'd1};
          else if (w_kev && w_key == K_LEFT)
            w_sub_n = {2'd0, r_sub[1:0] - 2'd1};
          else if (w_enter) begin
            w_sel_n  = r_sub[1:0];
            w_page_n = (r_sub[1:0] == ACT_FIGHT) ? PG_ATTACK : PG_DODGE;
            w_sub_n  = 4'd0;
            w_cnt_n  = '0;
          end
        end
        PG_ATTACK: begin
          // ENTER is checked first so a coincident step never moves the marker.
          if (w_enter) begin
            w_fire_n  = 1'b1;
            w_power_n = atk_power(r_sub);
            w_page_n  = PG_DODGE;
            w_sub_n   = 4'd0;
            w_cnt_n   = '0;
          end else if (tick) begin
            if (r_cnt == STEP_LAST) begin
              w_cnt_n = '0;
              if (r_sub == 4'd15) begin
                w_fire_n  = 1'b1;
                w_power_n = 4'd0;
                w_page_n  = PG_DODGE;
                w_sub_n   = 4'd0;
              end else
                w_sub_n = r_sub + 4'd1;
            end else
              w_cnt_n = r_cnt + 1'b1;
          end
        end
        PG_DODGE: begin
          if (tick) begin
            if (r_cnt == DODGE_LAST) begin
              // Return to the menu entry the player last confirmed.
              w_page_n = PG_ACTION;
              w_sub_n  = {2'd0, action_sel};
              w_cnt_n  = '0;
            end else
              w_cnt_n = r_cnt + 1'b1;
          end
        end
        PG_GAMEOVER, PG_WIN: begin
          if (w_enter) begin
            w_page_n = PG_MENU;
            w_sub_n  = 4'd0;
          end
        end
        default: begin
          w_page_n = PG_NULL;
          w_sub_n  = 4'd0;
          w_cnt_n  = '0;
        end
      endcase
    end

    // Movement follows the raw key level, but only while the next page is DODGE.
    w_pi_n = K_IDLE;
    if (w_page_n == PG_DODGE && keyboard >= K_UP && keyboard <= K_RIGHT)
      w_pi_n = keyboard;
  end

endmodule

// File: tb/tb_battle_sequencer.sv
module tb_battle_sequencer;
  import battle_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] keyboard = 4'd0;
  logic       isDeath = 1'b0;
  logic       monster_dead = 1'b0;
  logic [7:0] state;
  logic [3:0] player_instruction;
  logic       is_move;
  logic       attack_fire;
  logic [3:0] attack_power;
  logic [1:0] action_sel;

  int n_chk = 0;
  int n_err = 0;

  battle_sequencer #(
    .START_TICKS(3), .ATTACK_STEP(1), .DODGE_TICKS(5), .CNT_W(12)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .keyboard(keyboard),
    .isDeath(isDeath), .monster_dead(monster_dead), .state(state),
    .player_instruction(player_instruction), .is_move(is_move),
    .attack_fire(attack_fire), .attack_power(attack_power),
    .action_sel(action_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Key event registers on the first edge, FSM acts on the second.
  task automatic press(input logic [3:0] k);
    keyboard = k;
    cyc(1);
    keyboard = 4'd0;
    cyc(1);
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
    end
  endtask

  initial begin
    cyc(2);
    chk("rst_state", state, 8'h00);
    chk("rst_move", is_move, 0);
    chk("rst_fire", attack_fire, 0);
    chk("rst_power", attack_power, 0);
    chk("rst_sel", action_sel, 0);
    reset = 1'b0;
    cyc(1);
    chk("null_to_menu", state, 8'h10);

    // MENU cursor toggle, then held ENTER
    press(K_DOWN);
    chk("menu_down1", state, 8'h11);
    press(K_ENTER);
    chk("menu_enter_credit_ignored", state, 8'h11);
    press(K_DOWN);
    chk("menu_down2", state, 8'h10);
    keyboard = K_ENTER;
    cyc(5);
    keyboard = 4'd0;
    chk("menu_to_start", state, 8'h80);
    cyc(1);

    // START for 3 ticks
    tick_n(2);
    chk("start_wait", state, 8'h80);
    tick_n(1);
    chk("start_to_action", state, 8'hB0);

    press(K_LEFT);
    chk("action_left_wrap", state, 8'hB3);
    press(K_RIGHT);
    chk("action_right_wrap", state, 8'hB0);
    press(K_ENTER);
    chk("action_fight", state, 8'hA0);
    chk("action_sel0", action_sel, 0);

    // ATTACK hit at marker 8
    tick_n(8);
    chk("marker8", state, 8'hA8);
    chk("no_fire_yet", attack_fire, 0);
    press(K_ENTER);
    chk("fire8", attack_fire, 1);
    chk("power8", attack_power, 8);
    chk("atk_to_dodge", state, 8'h90);
    keyboard = K_UP;
    cyc(1);
    chk("fire_pulse_end", attack_fire, 0);
    chk("power_held", attack_power, 8);
    chk("dodge_pi_up", player_instruction, 1);
    chk("dodge_move", is_move, 1);
    tick_n(4);
    chk("dodge_wait", state, 8'h90);
    chk("dodge_pi_held", player_instruction, 1);
    tick_n(1);
    chk("dodge_to_action", state, 8'hB0);
    chk("dodge_pi_off", player_instruction, 0);
    chk("dodge_move_off", is_move, 0);
    keyboard = 4'd0;
    cyc(1);

    // ATTACK hit at marker 5
    press(K_ENTER);
    tick_n(5);
    chk("marker5", state, 8'hA5);
    press(K_ENTER);
    chk("fire5", attack_fire, 1);
    chk("power5", attack_power, 5);
    chk("atk5_to_dodge", state, 8'h90);
    tick_n(5);
    chk("back_action2", state, 8'hB0);

    // ATTACK miss
    press(K_ENTER);
    tick_n(15);
    chk("marker15", state, 8'hAF);
    chk("no_fire_15", attack_fire, 0);
    tick_n(1);
    chk("miss_fire", attack_fire, 1);
    chk("miss_power", attack_power, 0);
    chk("miss_to_dodge", state, 8'h90);
    tick_n(5);
    chk("back_action3", state, 8'hB0);

    // Non-fight action preserves cursor through DODGE
    press(K_RIGHT);
    chk("action_right", state, 8'hB1);
    press(K_ENTER);
    chk("act_to_dodge", state, 8'h90);
    chk("action_sel1", action_sel, 1);
    tick_n(5);
    chk("cursor_kept", state, 8'hB1);
    press(K_LEFT);
    press(K_ENTER);
    chk("fight_again", state, 8'hA0);

    // Death + win + pending ENTER in ATTACK
    keyboard = K_ENTER;
    cyc(1);
    keyboard = 4'd0;
    isDeath = 1'b1;
    monster_dead = 1'b1;
    cyc(1);
    isDeath = 1'b0;
    monster_dead = 1'b0;
    chk("death_prio", state, 8'hC0);
    chk("death_no_fire", attack_fire, 0);
    chk("death_power_held", attack_power, 0);
    cyc(1);
    press(K_ENTER);
    chk("gameover_to_menu", state, 8'h10);

    // WIN from START
    press(K_ENTER);
    chk("menu_start2", state, 8'h80);
    monster_dead = 1'b1;
    cyc(1);
    monster_dead = 1'b0;
    chk("win", state, 8'hD0);
    press(K_ENTER);
    chk("win_to_menu", state, 8'h10);

    // Reset in the middle of DODGE
    press(K_ENTER);
    tick_n(3);
    press(K_RIGHT);
    press(K_ENTER);
    chk("dodge2", state, 8'h90);
    keyboard = K_DOWN;
    cyc(1);
    chk("dodge2_move", is_move, 1);
    chk("dodge2_pi", player_instruction, 3);
    keyboard = 4'd0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state", state, 8'h00);
    chk("async_rst_move", is_move, 0);
    chk("async_rst_pi", player_instruction, 0);
    chk("async_rst_sel", action_sel, 0);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("rst_release_menu", state, 8'h10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
